resp_misr: RTL and testbench
============================

RESP_MISR -- requirements
Module: resp_misr

Interface
REQ-001 SHALL have parameter SIG_W, default 16: MISR/signature width, legal range 4..32.
REQ-002 SHALL have parameter POLY, default 16'h1021: MISR feedback polynomial, SIG_W bits.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  begin a compaction run; sampled only in IDLE or DONE.
REQ-006 SHALL have port pat_cnt  input  8  number of responses to compact; sampled with start.
REQ-007 SHALL have port seed  input  SIG_W  initial signature; sampled with start.
REQ-008 SHALL have port golden  input  SIG_W  expected final signature; sampled with start.
REQ-009 SHALL have port resp_valid  input  1  resp carries a valid circuit response.
REQ-010 SHALL have port resp  input  2  circuit-under-test response, {N16, N12}.
REQ-011 SHALL have port resp_ready  output  1  block accepts resp this cycle.
REQ-012 SHALL have port busy  output  1  high in LOAD, RUN and CHECK.
REQ-013 SHALL have port done  output  1  run complete; held high in DONE.
REQ-014 SHALL have port pass  output  1  final signature equalled golden; valid while done=1.
REQ-015 SHALL have port signature  output  SIG_W  current MISR contents, registered.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, RUN, CHECK, DONE.
REQ-017 IDLE/DONE: start=1 at an edge SHALL capture pat_cnt, seed, golden and enter LOAD; done and pass SHALL clear on that edge.
REQ-018 LOAD: one cycle; SHALL set signature=seed, count=captured pat_cnt; next state RUN, or CHECK if count=0.
REQ-019 RUN: resp_ready SHALL be 1; resp_ready SHALL be 0 in every other state.
REQ-020 A response SHALL be accepted only at an edge where resp_valid=1 and resp_ready=1; resp_valid while resp_ready=0 SHALL be ignored, not queued.
REQ-021 Per accepted response: next = (signature<<1, LSB 0) XOR (POLY if signature[SIG_W-1]=1, else 0) XOR zero-extended resp; count decrements by 1.
REQ-022 An accept with count=1 SHALL move the FSM to CHECK; RUN with resp_valid=0 SHALL hold all state.
REQ-023 CHECK: one cycle; on leaving it pass SHALL be set to (signature==golden), done to 1, and the state to DONE.
REQ-024 done SHALL rise exactly 2 edges after the final accept; signature SHALL be stable from the final accept until the next LOAD.
REQ-025 start in LOAD, RUN or CHECK SHALL be ignored.
REQ-026 pat_cnt=0 SHALL compare seed directly against golden; no response is accepted.
REQ-027 pat_cnt=255 SHALL accept exactly 255 responses without counter wrap.

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for clk, force IDLE, signature=0, count=0, busy=0, done=0, pass=0 and resp_ready=0, including mid-RUN.
REQ-029 After rst_n deasserts, the block SHALL stay in IDLE until start=1 at a clock edge.

Verification
REQ-030 seed=0x0000, golden=0x0000, pat_cnt=2, resp 2'b01 then 2'b10 -> signature 0x0001 then 0x0000; done=1 and pass=1, 2 edges after the second accept.
REQ-031 seed=0x8000, pat_cnt=1, resp=2'b00, golden=0x1021 -> signature=0x1021, pass=1; repeat with golden=0x1020 -> pass=0, done=1.
REQ-032 pat_cnt=3 with resp_valid toggled 1,0,0,1,0,1 -> exactly 3 accepts; signature unchanged on idle cycles; no accept after count reaches 0.
REQ-033 rst_n pulsed low mid-RUN after 1 of 4 accepts -> all outputs 0 asynchronously, no clock edge needed; a fresh start then runs a clean 4-response compaction.
REQ-034 pat_cnt=0, seed=golden=0xBEEF -> LOAD then CHECK; done=1 and pass=1 at the 3rd edge after start; resp_ready stays 0 throughout.
REQ-035 start held high through a RUN -> ignored until DONE; in DONE it restarts the run, clearing done and pass.

Source files
------------

// File: rtl/resp_misr.sv
// -----------------------------------------------------------------------------
// resp_misr
//
// Response compactor built on a multiple-input signature register (MISR).
// A run is started with a pattern count, a seed and a golden signature. The
// block then folds that many 2-bit circuit responses into the signature and
// finally compares the result against the golden value.
//
// Ports
//   clk         sole clock, rising-edge active
//   rst_n       asynchronous active-low reset
//   start       begin a run (only honoured in IDLE or DONE)
//   pat_cnt     number of responses to compact, captured with start
//   seed        initial signature, captured with start
//   golden      expected final signature, captured with start
//   resp_valid  resp carries a valid response
//   resp        2-bit response {N16, N12}
//   resp_ready  block accepts resp this cycle (RUN only)
//   busy        high in LOAD, RUN and CHECK
//   done        run complete, held high in DONE
//   pass        final signature matched golden (valid while done=1)
//   signature   current MISR contents
// -----------------------------------------------------------------------------
module resp_misr #(
    parameter int unsigned      SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = 16'h1021
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       pat_cnt,
    input  logic [SIG_W-1:0] seed,
    input  logic [SIG_W-1:0] golden,
    input  logic             resp_valid,
    input  logic [1:0]       resp,
    output logic             resp_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // One MISR step: shift left, fold in the polynomial when the bit shifted
    // out was set, then XOR the zero-extended response into the low bits.
    function automatic logic [SIG_W-1:0] misr_step(
        input logic [SIG_W-1:0] sig,
        input logic [1:0]       r
    );
        logic [SIG_W-1:0] fb;
        logic [SIG_W-1:0] shifted;
        logic [SIG_W-1:0] resp_ext;
        if (sig[SIG_W-1]) begin
            fb = POLY;
        end else begin
            fb = {SIG_W{1'b0}};
        end
        shifted  = {sig[SIG_W-2:0], 1'b0};
        resp_ext = {{(SIG_W-2){1'b0}}, r};
        return shifted ^ fb ^ resp_ext;
    endfunction

    state_e           state_q,      state_d;
    logic [7:0]       count_q,      count_d;
    logic [7:0]       cap_cnt_q,    cap_cnt_d;
    logic [SIG_W-1:0] cap_seed_q,   cap_seed_d;
    logic [SIG_W-1:0] cap_golden_q, cap_golden_d;
    logic [SIG_W-1:0] signature_q,  signature_d;
    logic             busy_q,       busy_d;
    logic             resp_ready_q, resp_ready_d;
    logic             done_q,       done_d;
    logic             pass_q,       pass_d;
    logic             accept_s;

    // A response is taken only when the advertised ready and valid coincide;
    // valid seen while not ready is simply dropped.
    assign accept_s = resp_valid & resp_ready_q;

    // Next-state, datapath and output-flag computation.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        cap_cnt_d    = cap_cnt_q;
        cap_seed_d   = cap_seed_q;
        cap_golden_d = cap_golden_q;
        signature_d  = signature_q;
        done_d       = done_q;
        pass_d       = pass_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    cap_cnt_d    = pat_cnt;
                    cap_seed_d   = seed;
                    cap_golden_d = golden;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    state_d      = ST_LOAD;
                end else begin
                    state_d = state_q;
                end
            end
            ST_LOAD: begin
                signature_d = cap_seed_q;
                count_d     = cap_cnt_q;
                // A zero-length run compares the seed directly.
                if (cap_cnt_q == 8'd0) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept_s) begin
                    signature_d = misr_step(signature_q, resp);
                    count_d     = count_q - 8'd1;
                    // Last response: leave RUN before count can wrap.
                    if (count_q == 8'd1) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_CHECK: begin
                pass_d  = (signature_q == cap_golden_q);
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flags are decoded from the next state so they can be
        // registered and still line up with the state they describe.
        case (state_d)
            ST_LOAD, ST_RUN, ST_CHECK: busy_d = 1'b1;
            default:                   busy_d = 1'b0;
        endcase

        if (state_d == ST_RUN) begin
            resp_ready_d = 1'b1;
        end else begin
            resp_ready_d = 1'b0;
        end
    end

    // State, datapath and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            count_q      <= 8'd0;
            cap_cnt_q    <= 8'd0;
            cap_seed_q   <= {SIG_W{1'b0}};
            cap_golden_q <= {SIG_W{1'b0}};
            signature_q  <= {SIG_W{1'b0}};
            busy_q       <= 1'b0;
            resp_ready_q <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            cap_cnt_q    <= cap_cnt_d;
            cap_seed_q   <= cap_seed_d;
            cap_golden_q <= cap_golden_d;
            signature_q  <= signature_d;
            busy_q       <= busy_d;
            resp_ready_q <= resp_ready_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end

    assign resp_ready = resp_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign signature  = signature_q;

endmodule

// File: tb/tb_resp_misr.sv
// -----------------------------------------------------------------------------
// tb_resp_misr
//
// Directed bench for resp_misr. A run-level model predicts busy, resp_ready,
// done, pass and signature after every rising edge; a compare process checks
// the DUT against it on each falling edge. Hand-computed literals pin key
// signatures, latencies and accept counts independently of the model.
// -----------------------------------------------------------------------------
module tb_resp_misr;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  pat_cnt;
    logic [15:0] seed;
    logic [15:0] golden;
    logic        resp_valid;
    logic [1:0]  resp;
    logic        resp_ready;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] signature;

    int n_total = 0;
    int n_pass  = 0;
    int dut_acc = 0;
    bit chk_en  = 1'b0;

    // model state
    bit          m_busy, m_loaded, m_ready, m_done, m_pass;
    int          m_left;
    logic [15:0] m_sig, m_seed, m_gold;
    logic [7:0]  m_cnt;

    resp_misr dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pat_cnt    (pat_cnt),
        .seed       (seed),
        .golden     (golden),
        .resp_valid (resp_valid),
        .resp       (resp),
        .resp_ready (resp_ready),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .signature  (signature)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Signature update written as arithmetic on the integer value.
    function automatic logic [15:0] ref_misr(input logic [15:0] s, input logic [1:0] r);
        int v;
        v = (int'(s) * 2) % 65536;
        if (int'(s) >= 32768) v = v ^ 32'h0000_1021;
        v = v ^ int'(r);
        return v[15:0];
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_loaded = 1'b0; m_ready = 1'b0;
        m_done = 1'b0; m_pass = 1'b0; m_left = 0; m_sig = 16'h0000;
    endtask

    // Advance the run-level model by one rising edge using the applied inputs.
    task automatic model_step();
        if (!m_busy) begin
            if (start) begin
                m_cnt = pat_cnt; m_seed = seed; m_gold = golden;
                m_busy = 1'b1; m_loaded = 1'b0; m_ready = 1'b0;
                m_done = 1'b0; m_pass = 1'b0;
            end
        end else if (!m_loaded) begin
            m_loaded = 1'b1;
            m_sig    = m_seed;
            m_left   = int'(m_cnt);
            m_ready  = (m_left != 0);
        end else if (m_ready) begin
            if (resp_valid) begin
                m_sig  = ref_misr(m_sig, resp);
                m_left = m_left - 1;
                if (m_left == 0) m_ready = 1'b0;
            end
        end else begin
            m_done = 1'b1;
            m_pass = (m_sig == m_gold);
            m_busy = 1'b0;
        end
    endtask

    task automatic step();
        if (resp_valid && resp_ready) dut_acc++;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic launch(input logic [7:0] c, input logic [15:0] s, input logic [15:0] g);
        pat_cnt = c; seed = s; golden = g; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Compare process: DUT outputs against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_busy",       busy,       m_busy);
            check("cmp_resp_ready", resp_ready, m_ready);
            check("cmp_done",       done,       m_done);
            check("cmp_pass",       pass,       m_pass);
            check("cmp_signature",  signature,  m_sig);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; pat_cnt = 8'd0; seed = 16'h0000;
        golden = 16'h0000; resp_valid = 1'b0; resp = 2'b00;
        model_reset();
        #1;
        check("rst_signature",  signature,  32'h0);
        check("rst_busy",       busy,       32'h0);
        check("rst_done",       done,       32'h0);
        check("rst_pass",       pass,       32'h0);
        check("rst_resp_ready", resp_ready, 32'h0);
        @(negedge clk);
        rst_n = 1'b1; chk_en = 1'b1;
        step(); step();
        check("idle_hold_busy", busy, 32'h0);

        // Two responses from a zero seed
        launch(8'd2, 16'h0000, 16'h0000);
        step();
        check("s1_ready", resp_ready, 32'h1);
        resp_valid = 1'b1; resp = 2'b01;
        step();
        check("s1_sig1", signature, 32'h0001);
        resp = 2'b10;
        step();
        check("s1_sig2", signature, 32'h0000);
        resp_valid = 1'b0;
        check("s1_done_early", done, 32'h0);
        step();
        check("s1_done", done, 32'h1);
        check("s1_pass", pass, 32'h1);
        step();

        // Polynomial feedback, matching then mismatching golden
        launch(8'd1, 16'h8000, 16'h1021);
        check("s2_done_clr", done, 32'h0);
        step();
        resp_valid = 1'b1; resp = 2'b00;
        step();
        resp_valid = 1'b0;
        check("s2_sig", signature, 32'h1021);
        step();
        check("s2_pass", pass, 32'h1);
        launch(8'd1, 16'h8000, 16'h1020);
        check("s2b_pass_clr", pass, 32'h0);
        step();
        resp_valid = 1'b1;
        step();
        resp_valid = 1'b0;
        step();
        check("s2b_done", done, 32'h1);
        check("s2b_pass", pass, 32'h0);

        // Gapped valid: 1,0,0,1,0,1 then valid stays high after the last accept
        dut_acc = 0;
        launch(8'd3, 16'h1234, 16'h91A9);
        step();
        resp_valid = 1'b1; resp = 2'b11; step();
        resp_valid = 1'b0; resp = 2'b00; step();
        check("s3_hold_sig", signature, 32'h246B);
        step();
        resp_valid = 1'b1; resp = 2'b10; step();
        resp_valid = 1'b0; resp = 2'b00; step();
        resp_valid = 1'b1; resp = 2'b01; step();
        step(); step();
        resp_valid = 1'b0;
        check("s3_accepts", dut_acc, 32'd3);
        check("s3_sig", signature, 32'h91A9);
        check("s3_pass", pass, 32'h1);

        // Asynchronous reset mid-run, then a clean four-response run
        launch(8'd4, 16'hAAAA, 16'h0BEC);
        step();
        resp_valid = 1'b1; resp = 2'b01;
        step();
        resp_valid = 1'b0;
        check("s4_partial_sig", signature, 32'h4574);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("s4_rst_sig",   signature,  32'h0);
        check("s4_rst_busy",  busy,       32'h0);
        check("s4_rst_ready", resp_ready, 32'h0);
        check("s4_rst_done",  done,       32'h0);
        check("s4_rst_pass",  pass,       32'h0);
        #1;
        rst_n = 1'b1;
        step(); step();
        check("s4_idle_after_rst", busy, 32'h0);
        dut_acc = 0;
        launch(8'd4, 16'hAAAA, 16'h0BEC);
        step();
        resp_valid = 1'b1;
        resp = 2'b01; step();
        resp = 2'b10; step();
        resp = 2'b11; step();
        resp = 2'b00; step();
        resp_valid = 1'b0;
        step();
        check("s4_sig",     signature, 32'h0BEC);
        check("s4_accepts", dut_acc,   32'd4);
        check("s4_pass",    pass,      32'h1);

        // Zero-length run: seed compared directly, ready never raised
        dut_acc = 0;
        resp_valid = 1'b1;
        launch(8'd0, 16'hBEEF, 16'hBEEF);
        check("s5_e1_ready", resp_ready, 32'h0);
        step();
        check("s5_e2_ready", resp_ready, 32'h0);
        check("s5_e2_done",  done,       32'h0);
        step();
        check("s5_e3_done", done, 32'h1);
        check("s5_e3_pass", pass, 32'h1);
        check("s5_sig",     signature, 32'hBEEF);
        resp_valid = 1'b0;
        check("s5_accepts", dut_acc, 32'd0);

        // start held high: ignored while busy, restarts from DONE
        pat_cnt = 8'd2; seed = 16'h0000; golden = 16'h0003;
        start = 1'b1; resp_valid = 1'b1; resp = 2'b01;
        step(); step(); step(); step(); step();
        check("s6_done", done, 32'h1);
        check("s6_pass", pass, 32'h1);
        check("s6_sig",  signature, 32'h0003);
        step();
        check("s6_restart_done", done, 32'h0);
        check("s6_restart_busy", busy, 32'h1);
        start = 1'b0;
        step(); step(); step(); step();
        check("s6_done2", done, 32'h1);
        resp_valid = 1'b0;

        // Maximum count: exactly 255 accepts, no wrap
        dut_acc = 0;
        launch(8'd255, 16'h5A5A, 16'h0000);
        resp_valid = 1'b1;
        for (int i = 0; i < 257; i++) begin
            resp = 2'(i % 4);
            step();
        end
        check("s7_done",     done,    32'h1);
        check("s7_accepts",  dut_acc, 32'd255);
        step();
        check("s7_no_extra", dut_acc, 32'd255);
        resp_valid = 1'b0;
        step();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
